inst_fetch_interface: RTL
=========================

Name: inst_fetch_interface

Overview:
- Memory-side responder for inst_cache. It accepts miss requests (interface_enable, interface_PC) and issues a single-beat read on the SRAM-like instruction bus.
- It returns the fetched word with its PC (interface_instruction, this_time_pc) and holds cache_wait_stop_choke high until that word is valid for the current PC.
- Sits between inst_cache and the bus bridge or instruction RAM.

Parameters:
- KSEG_MAP, 1: when 1, addresses with PC[31:29] = 3'b100 or 3'b101 are issued with bits [31:29] cleared; others pass unchanged. When 0, all addresses pass unchanged.
- RESET_DATA, 32'h0000_0000: reset value of the held instruction register.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- interface_enable  in  1  cache miss on interface_PC
- interface_PC  in  32  PC requested by the cache
- this_time_pc  out  32  PC that interface_instruction belongs to
- interface_instruction  out  32  fetched instruction
- cache_wait_stop_choke  out  1  1 = CPU/cache must stall; 0 = cache may write
- inst_req  out  1  bus read request
- inst_addr  out  32  bus address (mapped, word-aligned)
- inst_addr_ok  in  1  request accepted this cycle
- inst_data_ok  in  1  read data valid this cycle
- inst_rdata  in  32  read data

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Registers: state, req_pc[31:0], data_q[31:0].
- Reset values: state = IDLE, req_pc = 0, data_q = RESET_DATA.
- Outputs during reset: inst_req = 0, cache_wait_stop_choke = 1.
- IDLE:
  - inst_req = 0.
  - If interface_enable: req_pc <= interface_PC, go to REQ.
- REQ:
  - inst_req = 1 and inst_addr = map(req_pc) with bits [1:0] forced to 0.
  - Address is held stable until inst_addr_ok.
  - inst_addr_ok && inst_data_ok in the same cycle: data_q <= inst_rdata, go to DONE.
  - inst_addr_ok only: go to WAIT.
  - Otherwise stay in REQ.
- WAIT:
  - inst_req = 0.
  - On inst_data_ok: data_q <= inst_rdata, go to DONE.
  - An accepted request is never cancelled.
- DONE (one cycle):
  - If interface_PC == req_pc, the word is delivered this cycle; go to IDLE.
  - If interface_PC != req_pc (stale fetch, e.g. a redirect during the miss) and interface_enable: discard, req_pc <= interface_PC, go to REQ.
  - If interface_PC != req_pc and !interface_enable: go to IDLE.
- Combinational outputs:
  - deliver = (state == DONE) && (interface_PC == req_pc)
  - cache_wait_stop_choke = reset | (interface_enable & ~deliver)
  - this_time_pc = deliver ? req_pc : interface_PC. Outside deliver, a hit rewrites the same line harmlessly.
  - interface_instruction = data_q at all times.
- Minimum miss latency: enable seen at cycle 0 → REQ at cycle 1 → addr_ok and data_ok at cycle 1 → DONE with choke = 0 at cycle 2.
  - General case: choke falls one cycle after data_ok.
- Addresses with PC[1:0] != 0 are forwarded aligned. The cache tags them separately, and alignment exceptions are handled upstream.
- Mid-operation reset returns to IDLE immediately and drops inst_req. The bus slave shares the reset, so no response is outstanding afterwards.
- interface_enable deasserting in REQ or WAIT does not abort; the transaction completes and DONE then applies the stale rule.

Decomposition:
- Shared package cpu_bus_pkg:
  - state enum {IDLE, REQ, WAIT, DONE}
  - KSEG0_HI = 3'b100, KSEG1_HI = 3'b101
  - function map_vaddr(pc, KSEG_MAP)
- No sub-module is needed; a single FSM with a datapath (≈150 lines).

Test Plan:
- Hit pass-through: enable = 0, PC = 0xBFC0_0000 → inst_req stays 0, choke = 0, this_time_pc = 0xBFC0_0000.
- Zero-wait miss: enable = 1, PC = 0xBFC0_0004; addr_ok and data_ok together at cycle 1 with rdata = 0x2408_0001.
  - inst_addr = 0x1FC0_0004 at cycle 1.
  - Cycle 2: choke = 0, interface_instruction = 0x2408_0001, this_time_pc = 0xBFC0_0004.
- Delayed miss: addr_ok held low for 3 cycles, data_ok 4 cycles later.
  - inst_addr is stable throughout REQ.
  - choke = 1 until the cycle after data_ok.
- Stale redirect: in WAIT for PC = 0x8000_0100, switch interface_PC to 0x8000_0200 with enable = 1.
  - Old data is discarded, choke stays 1.
  - A new request is issued with inst_addr = 0x0000_0200, and that word is delivered.
- KSEG_MAP = 0: PC = 0xBFC0_0008 → inst_addr = 0xBFC0_0008.
- Reset mid-WAIT: assert reset for 1 cycle → inst_req = 0, choke = 1 during reset, state = IDLE, data_q = RESET_DATA; the next miss proceeds normally.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// ---------------------------------------------------------------------------
// cpu_bus_pkg
//   Types and helpers shared by the instruction-side bus blocks.
//   - fetch_state_t : states of the fetch FSM in inst_fetch_interface
//   - KSEG0_HI/KSEG1_HI : PC[31:29] patterns of the unmapped kernel segments
//   - map_vaddr()   : virtual-to-physical translation for kseg0/kseg1
// ---------------------------------------------------------------------------
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } fetch_state_t;

  localparam logic [2:0] KSEG0_HI = 3'b100;
  localparam logic [2:0] KSEG1_HI = 3'b101;

  // kseg0/kseg1 are direct windows onto the low 512 MB of physical memory,
  // so translation is just clearing the segment bits. Everything else is
  // passed through untouched.
  function automatic logic [31:0] map_vaddr(input logic [31:0] pc,
                                            input logic        kseg_map);
    logic [31:0] addr;
    addr = pc;
    if (kseg_map && ((pc[31:29] == KSEG0_HI) || (pc[31:29] == KSEG1_HI))) begin
      addr[31:29] = 3'b000;
    end
    return addr;
  endfunction

endpackage

// File: rtl/inst_fetch_interface.sv
// ---------------------------------------------------------------------------
// inst_fetch_interface
//   Memory-side responder for inst_cache. On a cache miss it issues one
//   single-beat read on the SRAM-like instruction bus, keeps the returned
//   word, and stalls the cache until that word matches the PC being asked for.
//
// Ports
//   clk, reset              : clock, synchronous active-high reset
//   interface_enable        : cache reports a miss on interface_PC
//   interface_PC[31:0]      : PC currently requested by the cache
//   this_time_pc[31:0]      : PC that interface_instruction belongs to
//   interface_instruction   : last fetched word
//   cache_wait_stop_choke   : 1 = stall, 0 = cache may write/continue
//   inst_req / inst_addr    : bus read request and word-aligned address
//   inst_addr_ok            : bus accepted the request this cycle
//   inst_data_ok/inst_rdata : read data valid this cycle
// ---------------------------------------------------------------------------
module inst_fetch_interface #(
  parameter bit          KSEG_MAP   = 1'b1,
  parameter logic [31:0] RESET_DATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        interface_enable,
  input  logic [31:0] interface_PC,
  output logic [31:0] this_time_pc,
  output logic [31:0] interface_instruction,
  output logic        cache_wait_stop_choke,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata
);
  import cpu_bus_pkg::*;

  fetch_state_t state_reg, state_next;
  logic [31:0]  req_pc_reg, req_pc_next;
  logic [31:0]  data_q_reg, data_q_next;
  logic         deliver;

  // The fetched word is only handed over if the cache is still asking for
  // the PC we fetched; a redirect during the miss makes it stale.
  assign deliver = (state_reg == DONE) && (interface_PC == req_pc_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      req_pc_reg <= '0;
      data_q_reg <= RESET_DATA;
    end else begin
      state_reg  <= state_next;
      req_pc_reg <= req_pc_next;
      data_q_reg <= data_q_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    req_pc_next = req_pc_reg;
    data_q_next = data_q_reg;
    case (state_reg)
      IDLE: begin
        if (interface_enable) begin
          req_pc_next = interface_PC;
          state_next  = REQ;
        end
      end
      REQ: begin
        // The bus may return data in the same cycle it accepts the address.
        if (inst_addr_ok) begin
          if (inst_data_ok) begin
            data_q_next = inst_rdata;
            state_next  = DONE;
          end else begin
            state_next  = WAIT;
          end
        end
      end
      WAIT: begin
        // Once accepted the read cannot be withdrawn, so we always wait it out.
        if (inst_data_ok) begin
          data_q_next = inst_rdata;
          state_next  = DONE;
        end
      end
      DONE: begin
        if (deliver) begin
          state_next = IDLE;
        end else if (interface_enable) begin
          req_pc_next = interface_PC;
          state_next  = REQ;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign inst_req              = (state_reg == REQ) && !reset;
  assign inst_addr             = map_vaddr(req_pc_reg, KSEG_MAP) & 32'hFFFF_FFFC;
  assign cache_wait_stop_choke = reset | (interface_enable & ~deliver);
  // Outside a delivery the cache sees its own PC echoed back, so a hit
  // simply rewrites the line it already holds.
  assign this_time_pc          = deliver ? req_pc_reg : interface_PC;
  assign interface_instruction = data_q_reg;

endmodule
